mult_seq_ctrl: RTL and testbench
================================

Name: mult_seq_ctrl

Overview:
- Sequencer and operand/result stage for the bit-serial multiplier mult_N16_CC16 (16-bit x 16-bit, 32-bit product in 16 cycles, one multiplier bit per cycle).
- Accepts an operand pair over a valid/ready handshake, clears the multiplier and drives the garbler operand in parallel. Serializes the evaluator operand LSB-first, one bit per cycle.
- Captures the combinational 32-bit product on the final serial cycle and holds it behind a valid/ready output handshake.

Parameters:
- N, 16, operand width; also the number of serial cycles.
- CNT_W, $clog2(N), width of the serial-cycle counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- a  in  N  garbler operand (multiplicand).
- b  in  N  evaluator operand (multiplier), serialized LSB-first.
- mult_clr  out  1  synchronous clear to the multiplier rst pin.
- g_out  out  N  to multiplier g_input; held for the whole operation.
- e_bit  out  1  to multiplier e_input[0].
- prod_in  in  2N  from multiplier o.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- product  out  2N  captured product.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, cnt=0, a_reg=0, b_sh=0, product=0.
  - out_valid=0, e_bit=0, g_out=0.
  - mult_clr=1 combinationally whenever rst=1.
  - Reset mid-operation abandons the operation; no partial product is ever presented.
- States: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - in_ready=1, mult_clr=0, e_bit=0.
  - On in_valid at an edge: a_reg<=a, b_sh<=b, cnt<=0, go to CLEAR.
- CLEAR (1 cycle):
  - mult_clr=1, e_bit=0, g_out=a_reg. Multiplier registers are zeroed at the end of this cycle.
  - Go to RUN.
- RUN (exactly N cycles, cnt 0..N-1):
  - e_bit=b_sh[0], g_out=a_reg, mult_clr=0.
  - Each edge: b_sh<=b_sh>>1, cnt<=cnt+1.
  - At the edge where cnt==N-1: product<=prod_in, cnt<=0, go to DONE.
  - prod_in is not sampled at any other edge.
- DONE:
  - out_valid=1, product stable, e_bit=0, g_out=a_reg, mult_clr=0.
  - On out_ready at an edge: out_valid<=0, go to IDLE.
  - out_ready is ignored outside DONE.
- in_ready is low in CLEAR/RUN/DONE. No new pair is accepted in the cycle a product is consumed; the next accept occurs at the earliest one cycle later, in IDLE.
- Latency: accept at edge T0; CLEAR is cycle T0..T0+1; RUN spans N cycles; out_valid rises after edge T0+N+1 (N+1 edges after acceptance).
  - With out_ready held high, throughput is one product per N+3 cycles.
- Arithmetic:
  - Unsigned.
  - product = a*b, full 2N bits, no truncation or overflow.
  - The counter never wraps past N-1.
- Boundary cases:
  - rst and in_valid asserted together: rst wins.
  - in_valid held high through DONE: not accepted until IDLE.
  - a=0 or b=0: product=0 after the full N cycles. There is no early termination; timing is data-independent (garbled-circuit requirement).

Decomposition:
- Shared package mult_pkg:
  - N, CNT_W;
  - state enum {IDLE, CLEAR, RUN, DONE};
  - a function ref_mult(a,b) for the bench.
- One natural sub-module: piso_shift_reg (N-bit parallel-load, serial-out LSB-first, with load and shift enables) for b_sh.
- FSM, counter and product register stay inline.
- Verification top: mult_seq_ctrl wired to mult_N16_CC16 (mult_clr->rst, g_out->g_input, e_bit->e_input[0], o->prod_in).

Test Plan:
- Basic: a=3, b=5, out_ready=1 -> out_valid rises exactly 17 edges after acceptance; product=0x0000000F; one-cycle out_valid pulse.
- Max operands: a=0xFFFF, b=0xFFFF -> product=0xFFFE0001. Serial e_bit sequence is sixteen 1s, each followed by e_bit=0 in DONE.
- Backpressure: a=0x1234, b=0x0100, out_ready=0 for 10 cycles then 1 -> product=0x00123400 held stable with out_valid=1 and in_ready=0 throughout; IDLE one cycle after the handshake.
- Reset mid-run: accept a=0x00FF, b=0x00FF, assert rst at RUN cnt=7 -> next cycle state=IDLE, out_valid=0, product=0, mult_clr=1 during rst. A subsequent a=2, b=7 yields 0x0000000E.
- Back-to-back with zero: in_valid held high with pairs (0,0xABCD) then (0xABCD,0x0002) -> products 0x00000000 then 0x0001579A, each after a full N-cycle RUN, with a second acceptance one cycle after the first product handshake.
- Random: 1000 pairs with random out_ready -> every product matches ref_mult; e_bit equals b[cnt] in every RUN cycle.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared sizing, FSM state encoding and a reference product for the
// sequencer of the 16x16 bit-serial multiplier.
package mult_pkg;

  localparam int N     = 16;
  localparam int CNT_W = $clog2(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [2*N-1:0] ref_mult(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-1:0] a_wide;
    logic [2*N-1:0] b_wide;
    a_wide = {{N{1'b0}}, a};
    b_wide = {{N{1'b0}}, b};
    return a_wide * b_wide;
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load, serial-out shift register; bit 0 leaves first, zeros fill from the top.
module piso_shift_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         sout
);

  logic [W-1:0] q_reg;
  logic [W-1:0] q_next;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      logic fill;
      if (gi == W - 1) begin : g_top
        assign fill = 1'b0;
      end else begin : g_mid
        assign fill = q_reg[gi+1];
      end
      // load takes priority so an accept never mixes old and new bits
      assign q_next[gi] = load ? din[gi] : (shift ? fill : q_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign sout = q_reg[0];

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer for the bit-serial multiplier: accepts an operand pair, clears the
// multiplier, streams the evaluator operand LSB-first and holds the product.
module mult_seq_ctrl #(
  parameter int N     = mult_pkg::N,
  parameter int CNT_W = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           mult_clr,
  output logic [N-1:0]   g_out,
  output logic           e_bit,
  input  logic [2*N-1:0] prod_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy
);

  mult_pkg::state_t state_reg;
  mult_pkg::state_t state_next;

  logic [CNT_W-1:0] cnt_reg;
  logic [N-1:0]     a_reg;
  logic [2*N-1:0]   product_reg;
  logic             accept;
  logic             last_run;
  logic             run_shift;
  logic             e_serial;

  assign accept    = (state_reg == mult_pkg::IDLE) && in_valid;
  assign run_shift = (state_reg == mult_pkg::RUN);
  assign last_run  = run_shift && (cnt_reg == CNT_W'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= mult_pkg::IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      mult_pkg::IDLE:  if (in_valid)  state_next = mult_pkg::CLEAR;
      mult_pkg::CLEAR: state_next = mult_pkg::RUN;
      mult_pkg::RUN:   if (last_run)  state_next = mult_pkg::DONE;
      mult_pkg::DONE:  if (out_ready) state_next = mult_pkg::IDLE;
      default:         state_next = mult_pkg::IDLE;
    endcase
  end

  // prod_in is only meaningful once all N multiplier bits have been applied
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg     <= '0;
      a_reg       <= '0;
      product_reg <= '0;
    end else begin
      if (accept) begin
        a_reg   <= a;
        cnt_reg <= '0;
      end
      if (last_run) begin
        product_reg <= prod_in;
        cnt_reg     <= '0;
      end else if (run_shift) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  piso_shift_reg #(
    .W(N)
  ) u_b_sh (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .shift(run_shift),
    .din  (b),
    .sout (e_serial)
  );

  always_comb begin
    in_ready  = 1'b0;
    mult_clr  = rst;
    e_bit     = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_reg)
      mult_pkg::IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      mult_pkg::CLEAR: mult_clr  = 1'b1;
      mult_pkg::RUN:   e_bit     = e_serial;
      mult_pkg::DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  assign g_out   = a_reg;
  assign product = product_reg;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl with a behavioural bit-serial multiplier attached;
// expected products go into a queue that a separate monitor drains.
module tb_mult_seq_ctrl;
  import mult_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        mult_clr;
  logic [15:0] g_out;
  logic        e_bit;
  logic [31:0] prod_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        busy;

  always #5 clk = ~clk;

  mult_seq_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .mult_clr (mult_clr),
    .g_out    (g_out),
    .e_bit    (e_bit),
    .prod_in  (prod_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product),
    .busy     (busy)
  );

  // Behavioural stand-in for mult_N16_CC16: adds g << k when the serial bit is 1.
  logic [31:0] acc_m;
  logic [3:0]  k_m;
  assign prod_in = acc_m + (e_bit ? ({16'd0, g_out} << k_m) : 32'd0);
  always @(posedge clk) begin
    if (mult_clr) begin
      acc_m <= '0;
      k_m   <= '0;
    end else begin
      acc_m <= prod_in;
      k_m   <= k_m + 4'd1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  int          hs_count = 0;
  int          hs_cyc   = 0;
  int          acc_cyc  = -1000;
  logic [15:0] cur_b    = '0;
  bit          ebit_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Monitor: a product handshake happens at the edge following this sample.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        timeout_fail("unexpected_product");
      end else begin
        chk("product", product, exp_q.pop_front());
      end
      $display("product handshake %0d: product=%h", hs_count, product);
      hs_count++;
      hs_cyc = cyc + 1;
    end
  end

  // Serial-stream and latency checker relative to the accept edge.
  always @(negedge clk) begin : ebit_chk
    int d;
    d = cyc - acc_cyc;
    if (ebit_en && !rst) begin
      if (d == 0) begin
        chk("clear_mult_clr", 32'(mult_clr), 32'd1);
      end else if (d >= 1 && d <= 16) begin
        chk("run_e_bit", 32'(e_bit), 32'(cur_b[d-1]));
        chk("run_no_valid", 32'(out_valid), 32'd0);
      end else if (d == 17) begin
        chk("done_e_bit", 32'(e_bit), 32'd0);
        chk("done_valid_latency", 32'(out_valid), 32'd1);
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic [31:0] ev,
                       input bit keep_valid);
    in_valid = 1'b1;
    a = av;
    b = bv;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        cur_b   = bv;
        exp_q.push_back(ev);
        if (!keep_valid) in_valid = 1'b0;
        $display("accept a=%h b=%h expect=%h at cycle %0d", av, bv, ev, cyc);
        return;
      end
    end
    timeout_fail("accept_wait");
  endtask

  task automatic wait_hs(input int target, input bit rnd);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (hs_count >= target) return;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
    end
    timeout_fail("handshake_wait");
  endtask

  initial begin
    logic [15:0] av;
    logic [15:0] bv;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #1;
    chk("rst_mult_clr", 32'(mult_clr), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_product", product, 32'd0);
    chk("rst_g_out", 32'(g_out), 32'd0);
    chk("rst_e_bit", 32'(e_bit), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // rst wins over a simultaneous in_valid
    in_valid = 1'b1; a = 16'd5; b = 16'd5;
    @(posedge clk);
    #1;
    chk("rst_beats_valid", 32'(busy), 32'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("idle_mult_clr", 32'(mult_clr), 32'd0);
    ebit_en = 1'b1;

    // Basic
    out_ready = 1'b1;
    issue(16'd3, 16'd5, 32'h0000000F, 1'b0);
    wait_hs(1, 1'b0);
    chk("pulse_valid_low", 32'(out_valid), 32'd0);
    chk("pulse_in_ready", 32'(in_ready), 32'd1);

    // Max operands
    issue(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b0);
    wait_hs(2, 1'b0);

    // Backpressure
    out_ready = 1'b0;
    issue(16'h1234, 16'h0100, 32'h00123400, 1'b0);
    repeat (17) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_product", product, 32'h00123400);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_hs(3, 1'b0);
    chk("bp_idle_ready", 32'(in_ready), 32'd1);
    chk("bp_idle_busy", 32'(busy), 32'd0);

    // Reset at RUN cnt=7
    issue(16'h00FF, 16'h00FF, 32'h0000FE01, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    ebit_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrun_mult_clr", 32'(mult_clr), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrun_in_ready", 32'(in_ready), 32'd1);
    chk("midrun_out_valid", 32'(out_valid), 32'd0);
    chk("midrun_product", product, 32'd0);
    chk("midrun_busy", 32'(busy), 32'd0);
    exp_q.delete();
    acc_cyc = -1000;
    ebit_en = 1'b1;
    issue(16'd2, 16'd7, 32'h0000000E, 1'b0);
    wait_hs(4, 1'b0);

    // Back-to-back with in_valid held high
    issue(16'h0000, 16'hABCD, 32'h00000000, 1'b1);
    issue(16'hABCD, 16'h0002, 32'h0001579A, 1'b0);
    chk("b2b_gap", 32'(acc_cyc - hs_cyc), 32'd1);
    wait_hs(6, 1'b0);

    // Random pairs with random out_ready
    for (int k = 0; k < 1000; k++) begin
      av = 16'($urandom);
      bv = 16'($urandom);
      issue(av, bv, ref_mult(av, bv), 1'b0);
      wait_hs(7 + k, 1'b1);
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
